// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU memory/IO slave: register offsets, CTRL/STATUS bit
// positions and reset values.
package cpu_io_pkg;

  typedef logic [2:0] io_ofs_t;

  localparam io_ofs_t GPIO_OUT_OFS  = 3'd0;
  localparam io_ofs_t GPIO_IN_OFS   = 3'd1;
  localparam io_ofs_t TIMER_CNT_OFS = 3'd2;
  localparam io_ofs_t TIMER_CMP_OFS = 3'd3;
  localparam io_ofs_t STATUS_OFS    = 3'd4;
  localparam io_ofs_t CTRL_OFS      = 3'd5;
  localparam int unsigned IO_REGS   = 6;

  localparam int unsigned CTRL_TEN    = 0;
  localparam int unsigned CTRL_PS_LSB = 1;
  localparam int unsigned CTRL_PS_MSB = 3;
  localparam int unsigned CTRL_MIE    = 4;
  localparam int unsigned CTRL_CIE    = 5;

  localparam int unsigned STAT_MATCH = 0;
  localparam int unsigned STAT_CHG   = 1;

  localparam logic [7:0] TIMER_CMP_RST = 8'hFF;

endpackage

// File: rtl/cpu_io_timer.sv
// Prescaled 8-bit timer with compare; match is a one-cycle pulse that the parent
// turns into a sticky STATUS flag on the same edge the counter wraps.
module cpu_io_timer
  import cpu_io_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ten,
  input  logic [2:0] ps,
  input  logic       ctrl_wr,
  input  logic       cnt_wr,
  input  logic [7:0] cmp,
  output logic [7:0] cnt,
  output logic       match
);

  logic [7:0] presc_q, presc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ps_mask;
  logic       tick;

  always_comb begin
    ps_mask = ~(8'hFF << ps);
    tick    = ten && ((presc_q & ps_mask) == ps_mask);

    presc_d = presc_q;
    if (ctrl_wr || cnt_wr) begin
      presc_d = '0;
    end else if (ten) begin
      presc_d = presc_q + 8'd1;
    end

    // A software clear of the counter beats a tick and suppresses the match.
    cnt_d = cnt_q;
    match = 1'b0;
    if (cnt_wr) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == cmp) begin
        cnt_d = '0;
        match = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_mem_io.sv
// Bus slave for the 8-bit CPU: scratch RAM, GPIO with input synchroniser, timer,
// sticky status flags and a registered interrupt line.
module cpu_mem_io
  import cpu_io_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 16,
  parameter logic [6:0]  IO_BASE   = 7'h70
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] bus_addr,
  input  logic [7:0] bus_wdata,
  input  logic       bus_we,
  output logic [7:0] bus_rdata,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       irq
);

  localparam int unsigned RamAw = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [7:0]       mem [RAM_DEPTH];
  logic [RamAw-1:0] ram_idx;
  logic             ram_hit, io_hit;
  logic [6:0]       io_diff;
  io_ofs_t          io_ofs;

  logic [7:0] gpio_out_q, cmp_q;
  logic [7:0] sync1_q, sync2_q, sync_prev_q;
  logic [1:0] status_q, status_d;
  logic [5:0] ctrl_q;
  logic       irq_q, irq_d;
  logic       wr_gpio, wr_cnt, wr_cmp, wr_status, wr_ctrl;
  logic [7:0] cnt;
  logic       match, chg;

  assign ram_hit = 32'(bus_addr) < RAM_DEPTH;
  assign ram_idx = bus_addr[RamAw-1:0];
  // Addresses below IO_BASE wrap to large differences and fall outside the block.
  assign io_diff = bus_addr - IO_BASE;
  assign io_hit  = !ram_hit && (io_diff < 7'(IO_REGS));
  assign io_ofs  = io_diff[2:0];

  always_comb begin
    wr_gpio   = 1'b0;
    wr_cnt    = 1'b0;
    wr_cmp    = 1'b0;
    wr_status = 1'b0;
    wr_ctrl   = 1'b0;
    if (bus_we && io_hit) begin
      case (io_ofs)
        GPIO_OUT_OFS:  wr_gpio   = 1'b1;
        TIMER_CNT_OFS: wr_cnt    = 1'b1;
        TIMER_CMP_OFS: wr_cmp    = 1'b1;
        STATUS_OFS:    wr_status = 1'b1;
        CTRL_OFS:      wr_ctrl   = 1'b1;
        default:       ;
      endcase
    end
  end

  cpu_io_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .ten     (ctrl_q[CTRL_TEN]),
    .ps      (ctrl_q[CTRL_PS_MSB:CTRL_PS_LSB]),
    .ctrl_wr (wr_ctrl),
    .cnt_wr  (wr_cnt),
    .cmp     (cmp_q),
    .cnt     (cnt),
    .match   (match)
  );

  assign chg = sync2_q != sync_prev_q;

  // Hardware set is applied after the write-1-to-clear so a coincident set wins.
  always_comb begin
    status_d = status_q;
    if (wr_status) status_d = status_q & ~bus_wdata[1:0];
    if (match)     status_d[STAT_MATCH] = 1'b1;
    if (chg)       status_d[STAT_CHG]   = 1'b1;
    irq_d = (status_q[STAT_MATCH] & ctrl_q[CTRL_MIE]) |
            (status_q[STAT_CHG]   & ctrl_q[CTRL_CIE]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out_q  <= '0;
      cmp_q       <= TIMER_CMP_RST;
      ctrl_q      <= '0;
      status_q    <= '0;
      irq_q       <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_prev_q <= '0;
    end else begin
      if (wr_gpio) gpio_out_q <= bus_wdata;
      if (wr_cmp)  cmp_q      <= bus_wdata;
      if (wr_ctrl) ctrl_q     <= bus_wdata[5:0];
      status_q    <= status_d;
      irq_q       <= irq_d;
      sync1_q     <= gpio_in;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  // RAM has no reset, but a write during reset is still suppressed.
  always_ff @(posedge clk) begin
    if (rst_n && bus_we && ram_hit) begin
      mem[ram_idx] <= bus_wdata;
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (ram_hit) begin
      bus_rdata = mem[ram_idx];
    end else if (io_hit) begin
      case (io_ofs)
        GPIO_OUT_OFS:  bus_rdata = gpio_out_q;
        GPIO_IN_OFS:   bus_rdata = sync2_q;
        TIMER_CNT_OFS: bus_rdata = cnt;
        TIMER_CMP_OFS: bus_rdata = cmp_q;
        STATUS_OFS:    bus_rdata = {6'b0, status_q};
        CTRL_OFS:      bus_rdata = {2'b0, ctrl_q};
        default:       bus_rdata = '0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_cpu_mem_io.sv
// Bench for cpu_mem_io: table vectors, hand sequences for timing corners, then
// random traffic against a behavioural model of the register map.
module tb_cpu_mem_io;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic [7:0] bus_rdata;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       irq;

  always #5 clk = ~clk;

  cpu_mem_io #(
    .RAM_DEPTH (16),
    .IO_BASE   (7'h70)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .irq       (irq)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] smp_rdata, smp_gpio;
  logic       smp_irq;
  bit         model_chk = 1'b0;

  // Behavioural model of the slave's architectural state.
  logic [7:0] m_ram [16];
  bit         m_ramv [16];
  logic [7:0] m_gpio, m_cnt, m_cmp, m_presc;
  logic [1:0] m_status;
  logic [5:0] m_ctrl;
  logic       m_irq;
  logic [7:0] m_pipe [3];  // [0],[1] synchroniser stages, [2] previous stage-2 value

  typedef struct {
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] m_read(input logic [6:0] a);
    if (a < 7'd16) return {m_ramv[a[3:0]], m_ram[a[3:0]]};
    case (a)
      7'h70:   return {1'b1, m_gpio};
      7'h71:   return {1'b1, m_pipe[1]};
      7'h72:   return {1'b1, m_cnt};
      7'h73:   return {1'b1, m_cmp};
      7'h74:   return {1'b1, 6'b0, m_status};
      7'h75:   return {1'b1, 2'b0, m_ctrl};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic model_clock(input logic r, input logic [6:0] a, input logic [7:0] wd,
                             input logic we, input logic [7:0] gin);
    int         period;
    bit         tick, cnt_wr, ctrl_wr;
    logic [7:0] n_cnt, n_presc;
    logic [1:0] n_status;
    logic       n_irq;
    if (!r) begin
      m_gpio = 8'h00; m_cnt = 8'h00; m_cmp = 8'hFF; m_status = 2'b00;
      m_ctrl = 6'h00; m_presc = 8'h00; m_irq = 1'b0;
      for (int k = 0; k < 3; k++) m_pipe[k] = 8'h00;
      return;
    end
    period  = 1 << m_ctrl[3:1];
    tick    = m_ctrl[0] && ((int'(m_presc) % period) == period - 1);
    cnt_wr  = we && (a == 7'h72);
    ctrl_wr = we && (a == 7'h75);
    n_irq   = (m_status[0] && m_ctrl[4]) || (m_status[1] && m_ctrl[5]);
    n_status = m_status;
    if (we && a == 7'h74) n_status = n_status & ~wd[1:0];
    if (tick && m_cnt == m_cmp && !cnt_wr) n_status[0] = 1'b1;
    if (m_pipe[1] != m_pipe[2]) n_status[1] = 1'b1;
    if (cnt_wr)     n_cnt = 8'h00;
    else if (tick)  n_cnt = (m_cnt == m_cmp) ? 8'h00 : m_cnt + 8'd1;
    else            n_cnt = m_cnt;
    if (cnt_wr || ctrl_wr) n_presc = 8'h00;
    else if (m_ctrl[0])    n_presc = m_presc + 8'd1;
    else                   n_presc = m_presc;
    if (we && a < 7'd16) begin
      m_ram[a[3:0]]  = wd;
      m_ramv[a[3:0]] = 1'b1;
    end
    if (we && a == 7'h70) m_gpio = wd;
    if (we && a == 7'h73) m_cmp  = wd;
    if (we && a == 7'h75) m_ctrl = wd[5:0];
    m_cnt = n_cnt; m_presc = n_presc; m_status = n_status; m_irq = n_irq;
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = gin;
  endtask

  // One bus cycle: drive just after the edge, sample at the falling edge, advance model.
  task automatic step(input logic [6:0] a, input logic [7:0] wd, input logic we);
    logic [8:0] e;
    bus_addr = a; bus_wdata = wd; bus_we = we;
    #4;
    smp_rdata = bus_rdata; smp_gpio = gpio_out; smp_irq = irq;
    if (model_chk) begin
      e = m_read(a);
      if (e[8]) check($sformatf("rand_rdata@%02h", a), smp_rdata, e[7:0]);
      check("rand_gpio_out", smp_gpio, m_gpio);
      check("rand_irq", {7'b0, smp_irq}, {7'b0, m_irq});
    end
    @(posedge clk);
    model_clock(rst_n, a, wd, we, gpio_in);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) m_ramv[k] = 1'b0;
    tbl[0]  = '{7'h70, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[1]  = '{7'h71, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[2]  = '{7'h72, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[3]  = '{7'h73, 8'h00, 1'b0, 1'b1, 8'hFF};
    tbl[4]  = '{7'h74, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{7'h75, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[6]  = '{7'h7F, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{7'h76, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[8]  = '{7'h03, 8'hA5, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{7'h0F, 8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{7'h00, 8'h11, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{7'h03, 8'h00, 1'b0, 1'b1, 8'hA5};
    tbl[12] = '{7'h0F, 8'h00, 1'b0, 1'b1, 8'h5A};
    tbl[13] = '{7'h10, 8'h77, 1'b1, 1'b1, 8'h00};
    tbl[14] = '{7'h10, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[15] = '{7'h00, 8'h00, 1'b0, 1'b1, 8'h11};
    tbl[16] = '{7'h7F, 8'hFF, 1'b1, 1'b1, 8'h00};
    tbl[17] = '{7'h7F, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[18] = '{7'h73, 8'h3C, 1'b1, 1'b1, 8'hFF};
    tbl[19] = '{7'h73, 8'h00, 1'b0, 1'b1, 8'h3C};
    tbl[20] = '{7'h74, 8'h03, 1'b1, 1'b1, 8'h00};
    tbl[21] = '{7'h76, 8'hFF, 1'b1, 1'b1, 8'h00};
    tbl[22] = '{7'h75, 8'h00, 1'b0, 1'b1, 8'h00};

    rst_n = 1'b0; gpio_in = 8'h00; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0;
    repeat (3) step(7'h00, 8'h00, 1'b0);
    rst_n = 1'b1;

    step(7'h70, 8'h00, 1'b0);
    check("reset_gpio_out", smp_gpio, 8'h00);
    check("reset_irq", {7'b0, smp_irq}, 8'h00);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].addr, tbl[i].wdata, tbl[i].we);
      if (tbl[i].chk) check($sformatf("table[%0d]", i), smp_rdata, tbl[i].exp);
    end

    // Timer: CMP=4, enable with match IRQ; count 0..4 then wrap.
    step(7'h73, 8'h04, 1'b1);
    step(7'h75, 8'h11, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(7'h72, 8'h00, 1'b0);
      check($sformatf("timer_cnt%0d", i), smp_rdata, 8'(i));
    end
    step(7'h72, 8'h00, 1'b0);
    check("timer_wrap_cnt", smp_rdata, 8'h00);
    check("timer_irq_latency", {7'b0, smp_irq}, 8'h00);
    step(7'h74, 8'h00, 1'b0);
    check("timer_match_flag", smp_rdata, 8'h01);
    check("timer_irq", {7'b0, smp_irq}, 8'h01);
    step(7'h75, 8'h10, 1'b1);
    step(7'h74, 8'h01, 1'b1);
    step(7'h74, 8'h00, 1'b0);
    check("status_w1c", smp_rdata, 8'h00);
    check("irq_hold_after_clear", {7'b0, smp_irq}, 8'h01);
    step(7'h74, 8'h00, 1'b0);
    check("irq_cleared", {7'b0, smp_irq}, 8'h00);

    // Prescale PS=3: one increment every 8 cycles; CNT write restarts the prescaler.
    step(7'h73, 8'hFF, 1'b1);
    step(7'h72, 8'h00, 1'b1);
    step(7'h75, 8'h07, 1'b1);
    for (int j = 0; j < 17; j++) begin
      step(7'h72, 8'h00, 1'b0);
      check($sformatf("presc_cnt%0d", j), smp_rdata, 8'(j / 8));
    end
    step(7'h72, 8'h55, 1'b1);
    for (int j = 0; j < 9; j++) begin
      step(7'h72, 8'h00, 1'b0);
      check($sformatf("presc_restart%0d", j), smp_rdata, 8'(j / 8));
    end
    step(7'h75, 8'h00, 1'b1);

    // GPIO input path with change IRQ enabled.
    step(7'h75, 8'h20, 1'b1);
    gpio_in = 8'h3C;
    step(7'h71, 8'h00, 1'b0);
    check("gpio_in_e0", smp_rdata, 8'h00);
    step(7'h71, 8'h00, 1'b0);
    check("gpio_in_e1", smp_rdata, 8'h00);
    step(7'h71, 8'h00, 1'b0);
    check("gpio_in_e2", smp_rdata, 8'h3C);
    step(7'h74, 8'h00, 1'b0);
    check("chg_flag_e3", smp_rdata, 8'h02);
    check("chg_irq_e3", {7'b0, smp_irq}, 8'h00);
    step(7'h74, 8'h00, 1'b0);
    check("chg_irq_e4", {7'b0, smp_irq}, 8'h01);
    step(7'h74, 8'h02, 1'b1);
    step(7'h70, 8'hC3, 1'b1);
    check("gpio_out_before", smp_gpio, 8'h00);
    step(7'h70, 8'h00, 1'b0);
    check("gpio_out_pin", smp_gpio, 8'hC3);
    check("gpio_out_read", smp_rdata, 8'hC3);

    // W1C coinciding with a match: CMP=0 so every tick matches.
    step(7'h73, 8'h00, 1'b1);
    step(7'h72, 8'h00, 1'b1);
    step(7'h75, 8'h01, 1'b1);
    step(7'h74, 8'h01, 1'b1);
    step(7'h74, 8'h00, 1'b0);
    check("w1c_vs_match", smp_rdata, 8'h01);
    step(7'h75, 8'h00, 1'b1);
    step(7'h74, 8'h01, 1'b1);
    step(7'h74, 8'h00, 1'b0);
    check("w1c_no_match", smp_rdata, 8'h00);

    // Reset beats a same-cycle GPIO_OUT write.
    rst_n = 1'b0;
    step(7'h70, 8'hFF, 1'b1);
    rst_n = 1'b1;
    step(7'h73, 8'h00, 1'b0);
    check("rst_vs_write_gpio", smp_gpio, 8'h00);
    check("rst_cmp", smp_rdata, 8'hFF);
    check("rst_irq", {7'b0, smp_irq}, 8'h00);

    // Random traffic checked every cycle against the model.
    model_chk = 1'b1;
    for (int i = 0; i < 800; i++) begin
      logic [6:0] a;
      logic [7:0] wd;
      int         sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      a = 7'($urandom_range(0, 31));
      else if (sel < 8) a = 7'($urandom_range(7'h70, 7'h77));
      else              a = 7'($urandom);
      wd = 8'($urandom);
      if (a == 7'h73) wd = wd & 8'h0F;
      if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      step(a, wd, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_io.md
Name: cpu_mem_io

Overview:
- Memory and I/O slave that sits directly on the 8-bit CPU core's bus: 7-bit address, 8-bit write data and write strobe.
- Returns read data to the CPU's data input.
- Provides a small scratch RAM and memory-mapped GPIO, an 8-bit prescaled timer with compare, and sticky status flags with an interrupt line.
- Replaces direct pin-level memory so the CPU runs self-contained programs.

Parameters:
- RAM_DEPTH, 16, number of scratch RAM bytes at 0x00..RAM_DEPTH-1; power of 2, 2..64.
- IO_BASE, 7'h70, base address of the I/O register block (6 registers).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- bus_addr  in  7  CPU address
- bus_wdata  in  8  CPU write data
- bus_we  in  1  CPU write strobe, 1 = write this cycle
- bus_rdata  out  8  read data to CPU, combinational from bus_addr and registered state
- gpio_in  in  8  asynchronous external inputs
- gpio_out  out  8  registered GPIO output
- irq  out  1  registered interrupt request

Behaviour:
- Reset: on a clk edge with rst_n=0, all registers take their reset values.
  - gpio_out=0x00, TIMER_CNT=0x00, TIMER_CMP=0xFF, STATUS=0x00, CTRL=0x00, prescaler=0, sync flops=0x00, irq=0.
  - RAM contents are not reset (undefined until written).
  - Reset asserted mid-operation overrides any write in the same cycle.
- Memory map:
  - 0x00..RAM_DEPTH-1: RAM, read/write.
  - IO_BASE+0 GPIO_OUT: RW.
  - +1 GPIO_IN: RO, synchronised input.
  - +2 TIMER_CNT: RO value; any write clears the counter and the prescaler.
  - +3 TIMER_CMP: RW.
  - +4 STATUS: bit0 timer match, bit1 input change; write-1-to-clear; other bits read 0.
  - +5 CTRL: bit0 timer enable, bits3:1 prescale select PS, bit4 match IRQ enable, bit5 change IRQ enable; bits7:6 read 0.
  - All other addresses: read 0x00, writes ignored.
- Bus timing:
  - Reads are zero-latency: bus_rdata is valid in the same cycle as bus_addr.
  - Writes commit at the rising edge where bus_we=1.
  - A read of an address in the cycle it is written returns the old value.
  - Reads have no side effects.
- Input synchroniser: two flop stages on gpio_in. GPIO_IN returns stage 2, so a pin change is visible 2 edges later.
  - A third register holds the previous stage-2 value.
  - Change flag sets on the edge where stage 2 differs from the previous value, i.e. 3 edges after the pin changes.
- Prescaler: 8-bit free-running counter, enabled only while CTRL.bit0=1.
  - tick=1 when the low PS bits of the prescaler are all ones; PS=0 means tick every cycle, PS=7 every 128 cycles.
  - A write to CTRL clears the prescaler.
- Timer: on a tick, if TIMER_CNT==TIMER_CMP then TIMER_CNT←0 and STATUS.bit0←1; otherwise TIMER_CNT←TIMER_CNT+1.
  - With CMP=0xFF the counter wraps 0xFF→0x00 and sets the flag.
  - A CNT-clear write and a tick in the same cycle: the clear wins and the flag does not set.
- STATUS flags: sticky.
  - A hardware set and a write-1-to-clear of the same bit in the same cycle: set wins.
  - Writing 0 has no effect.
- irq: registered, irq ← (STATUS.bit0 & CTRL.bit4) | (STATUS.bit1 & CTRL.bit5). One cycle of latency after the flag or enable changes.
- RAM index: bus_addr[log2(RAM_DEPTH)-1:0], decoded only when bus_addr < RAM_DEPTH. No aliasing.

Decomposition:
- Package cpu_io_pkg holds:
  - register offset constants (GPIO_OUT_OFS..CTRL_OFS)
  - CTRL bit positions (CTRL_TEN, CTRL_PS_LSB/MSB, CTRL_MIE, CTRL_CIE)
  - STATUS bit positions
  - reset value TIMER_CMP_RST=8'hFF
- One sub-module, cpu_io_timer: prescaler, counter, compare, match pulse output.
- Address decode, RAM, GPIO and STATUS stay in cpu_mem_io.

Test Plan:
- Reset, then read every I/O address → GPIO_OUT=0x00, TIMER_CNT=0x00, TIMER_CMP=0xFF, STATUS=0x00, CTRL=0x00, irq=0. Read 0x7F → 0x00.
- RAM: write 0xA5 to 0x03 and 0x5A to 0x0F, read back → 0xA5 / 0x5A. Write to 0x10 with RAM_DEPTH=16 → read 0x00; 0x00 is unchanged.
- Timer: CMP=0x04, CTRL=0x11 (enable, PS=0, MIE) → CNT steps 0,1,2,3,4,0.
  - STATUS.bit0=1 on the wrap edge; irq=1 one cycle later.
  - Write STATUS=0x01 → flag and irq clear.
- Prescale: CTRL=0x07 (PS=3, enabled), CMP=0xFF → CNT increments once every 8 cycles. Write to TIMER_CNT → CNT=0x00 and the prescaler restarts.
- GPIO: gpio_in 0x00→0x3C.
  - GPIO_IN reads 0x3C after 2 edges; STATUS.bit1 sets at edge 3.
  - With CTRL.bit5=1, irq rises at edge 4.
  - Write gpio_out=0xC3 → pin 0xC3 after the edge.
- Corner cases:
  - Write-1-to-clear STATUS in the same cycle as a timer match → bit0 stays 1.
  - rst_n=0 in the same cycle as a GPIO_OUT write of 0xFF → gpio_out=0x00.
